axi4l_read_slave: RTL and testbench
===================================

// Module: axi4l_read_slave
// PURPOSE
//  AXI4-Lite read-channel slave: the read-side counterpart of the write-address channel.
//  Accepts one read address on AR, fetches the word from a register-file read port with fixed latency.
//  Returns it on R with an OKAY/SLVERR response.
//  Sits between the AXI4-Lite interconnect and the block's register file; one outstanding read at a time.
// PARAMETERS
//  ADDR_W       32  width of ARADDR / reg_rd_addr (byte address)
//  DATA_W       32  width of RDATA / reg_rd_data
//  NUM_REGS     16  number of 32-bit registers; valid byte range [0, NUM_REGS*4)
//  RD_LATENCY   1   cycles from reg_rd_en high to reg_rd_data valid; legal 1..4
//  SECURE_ONLY  0   1: reject non-secure accesses (ARPROT[1]=1) with SLVERR
// PORTS
//  ACLK         in   1       clock
//  ARESETn      in   1       reset, asynchronous, active-high
//  ARVALID      in   1       read address valid
//  ARREADY      out  1       read address ready
//  ARADDR       in   ADDR_W  read byte address
//  ARPROT       in   3       protection type
//  RVALID       out  1       read data valid
//  RREADY       in   1       read data ready
//  RDATA        out  DATA_W  read data
//  RRESP        out  2       read response (00 OKAY, 10 SLVERR)
//  reg_rd_en    out  1       register-file read strobe, one cycle per accepted legal read
//  reg_rd_addr  out  ADDR_W  latched byte address presented with reg_rd_en
//  reg_rd_data  in   DATA_W  register-file data, valid RD_LATENCY cycles after reg_rd_en
//  reg_rd_err   in   1       register-file error, sampled with reg_rd_data
// BEHAVIOUR
//  Clocking/reset: ACLK; reset ARESETn, asynchronous, active-high.
//  Reset values: ARREADY=0, RVALID=0, RDATA=0, RRESP=00, reg_rd_en=0, reg_rd_addr=0, state=IDLE, counter=0.
//  ARREADY rises the first cycle after reset deasserts.
//  FSM states: IDLE, FETCH, WAIT, RESP; all outputs registered.
//  IDLE: ARREADY=1. ARVALID&ARREADY at edge E0 -> latch ARADDR, compute err flag, ARREADY<=0, go FETCH.
//  err flag = ARADDR[1:0]!=0 | ARADDR>=NUM_REGS*4 | (SECURE_ONLY & ARPROT[1]).
//  FETCH: one cycle; reg_rd_en=1 only if err flag clear; counter<=RD_LATENCY-1; go WAIT.
//  WAIT: while counter!=0, decrement. At counter==0 edge: RDATA<=err?0:reg_rd_data;
//   RRESP<=(err|reg_rd_err)?10:00; RVALID<=1; go RESP.
//  reg_rd_err is ignored when err flag set.
//  Latency: RVALID first high after edge E0+RD_LATENCY+1, same for legal and illegal reads.
//  RESP: RVALID, RDATA, RRESP held stable until RVALID&RREADY.
//  On the RVALID&RREADY edge: RVALID<=0, ARREADY<=1, go IDLE.
//  RREADY high before RVALID: legal, completes on the first RVALID cycle.
//  ARVALID while not IDLE: ignored (ARREADY=0); the master holds it, accepted on return to IDLE.
//  No back-to-back overlap: minimum 1 idle cycle between R handshake and next AR acceptance.
//  ARADDR/ARPROT sampled only on the AR handshake edge; later changes have no effect.
//  Reset mid-transaction: all outputs return to reset values immediately; the in-flight read is dropped.
//  Address compare uses ADDR_W-bit unsigned arithmetic; no wrap-around; highest legal address = NUM_REGS*4-4.
// STRUCTURE
//  axi4l_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, rd_state_t enum {IDLE,FETCH,WAIT,RESP}.
//  Sub-module axi4l_rd_decode: combinational err flag from ARADDR, ARPROT and parameters.
//  The FSM, latency counter and output registers stay in axi4l_read_slave.
// TESTING
//  Legal read: ARADDR=0x8, reg[2]=0xDEADBEEF, RD_LATENCY=1, RREADY=1
//   -> reg_rd_en one cycle, RVALID after E0+2, RDATA=0xDEADBEEF, RRESP=00.
//  Backpressure: RREADY=0 for 5 cycles -> RVALID/RDATA/RRESP stable; ARREADY=0 throughout;
//   ARVALID with ARADDR=0x4 presented meanwhile is accepted only after the R handshake.
//  Errors: ARADDR=0x40 (NUM_REGS=16), ARADDR=0x6, and SECURE_ONLY=1 with ARPROT=3'b010
//   -> no reg_rd_en, RDATA=0, RRESP=10, same latency as a legal read.
//  reg_rd_err=1 on a legal read of 0x0 -> RRESP=10, RDATA=reg_rd_data.
//  RD_LATENCY=4: reg_rd_data valid exactly 4 cycles after reg_rd_en -> captured; RVALID at E0+5.
//  Reset mid-transaction: assert ARESETn during WAIT and during RESP -> outputs return to reset values;
//   after release, ARREADY=1 and a fresh read of 0x0 completes normally.

Source files
------------

// File: rtl/axi4l_pkg.sv
// ---------------------------------------------------------------------------
// axi4l_pkg
// Shared types and constants for the AXI4-Lite read slave.
//   RESP_OKAY / RESP_SLVERR : RRESP encodings
//   CNT_W                   : width of the read-latency countdown (latency 1..4)
//   rd_state_t              : read FSM states
// ---------------------------------------------------------------------------
package axi4l_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Countdown holds RD_LATENCY-1, which tops out at 3.
  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    RESP
  } rd_state_t;

endpackage

// File: rtl/axi4l_rd_decode.sv
// ---------------------------------------------------------------------------
// axi4l_rd_decode
// Combinational legality check for an incoming read address.
// Ports:
//   araddr_i : byte address from AR channel
//   arprot_i : AR protection bits; only bit 1 (non-secure) matters here
//   err_o    : 1 when the read must be answered with SLVERR and no register
//              access (unaligned, out of range, or non-secure when blocked)
// ---------------------------------------------------------------------------
module axi4l_rd_decode #(
  parameter int ADDR_W      = 32,
  parameter int NUM_REGS    = 16,
  parameter int SECURE_ONLY = 0
) (
  input  logic [ADDR_W-1:0] araddr_i,
  input  logic [2:0]        arprot_i,
  output logic              err_o
);

  // First byte address past the register file; compared unsigned at full
  // address width so large addresses never wrap into the legal window.
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(NUM_REGS * 4);

  // Privileged/instruction bits carry no meaning for this register file.
  logic unusedProt;
  assign unusedProt = arprot_i[0] ^ arprot_i[2];

  assign err_o = (araddr_i[1:0] != 2'b00)
               | (araddr_i >= ADDR_LIMIT)
               | ((SECURE_ONLY != 0) & arprot_i[1]);

endmodule

// File: rtl/axi4l_read_slave.sv
// ---------------------------------------------------------------------------
// axi4l_read_slave
// AXI4-Lite read-channel slave in front of a register-file read port with a
// fixed read latency. One outstanding read at a time; all outputs registered.
// Ports:
//   ACLK, ARESETn         : clock, asynchronous active-high reset
//   ARVALID/ARREADY       : read address handshake
//   ARADDR, ARPROT        : read byte address and protection, sampled on the
//                           AR handshake only
//   RVALID/RREADY         : read data handshake
//   RDATA, RRESP          : read data and response (OKAY / SLVERR)
//   reg_rd_en/reg_rd_addr : one-cycle register-file read strobe and address
//   reg_rd_data/reg_rd_err: register-file data and error, RD_LATENCY cycles
//                           after reg_rd_en
// ---------------------------------------------------------------------------
module axi4l_read_slave
  import axi4l_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 16,
  parameter int RD_LATENCY  = 1,
  parameter int SECURE_ONLY = 0
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              ARVALID,
  output logic              ARREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [2:0]        ARPROT,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              reg_rd_en,
  output logic [ADDR_W-1:0] reg_rd_addr,
  input  logic [DATA_W-1:0] reg_rd_data,
  input  logic              reg_rd_err
);

  rd_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              arReady_q, arReady_d;
  logic              rValid_q, rValid_d;
  logic [DATA_W-1:0] rData_q, rData_d;
  logic [1:0]        rResp_q, rResp_d;
  logic              regRdEn_q, regRdEn_d;
  logic [ADDR_W-1:0] regRdAddr_q, regRdAddr_d;
  logic              decErr;

  axi4l_rd_decode #(
    .ADDR_W      (ADDR_W),
    .NUM_REGS    (NUM_REGS),
    .SECURE_ONLY (SECURE_ONLY)
  ) u_decode (
    .araddr_i (ARADDR),
    .arprot_i (ARPROT),
    .err_o    (decErr)
  );

  // State and output registers. Reset drops any in-flight read and returns
  // every output to its idle value straight away.
  always_ff @(posedge ACLK or posedge ARESETn) begin
    if (ARESETn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      arReady_q   <= 1'b0;
      rValid_q    <= 1'b0;
      rData_q     <= '0;
      rResp_q     <= RESP_OKAY;
      regRdEn_q   <= 1'b0;
      regRdAddr_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      arReady_q   <= arReady_d;
      rValid_q    <= rValid_d;
      rData_q     <= rData_d;
      rResp_q     <= rResp_d;
      regRdEn_q   <= regRdEn_d;
      regRdAddr_q <= regRdAddr_d;
    end
  end

  // Next-state logic. Outputs are computed one cycle ahead so they come
  // straight from flops. ARREADY is raised from IDLE on the first edge after
  // reset, which also gives the one idle cycle between an R handshake and
  // the next AR acceptance. The strobe is a single pulse during FETCH, and
  // illegal reads take exactly the same path so their latency matches.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    arReady_d   = arReady_q;
    rValid_d    = rValid_q;
    rData_d     = rData_q;
    rResp_d     = rResp_q;
    regRdEn_d   = 1'b0;
    regRdAddr_d = regRdAddr_q;

    case (state_q)
      IDLE: begin
        arReady_d = 1'b1;
        if (ARVALID && arReady_q) begin
          regRdAddr_d = ARADDR;
          err_d       = decErr;
          regRdEn_d   = !decErr;
          arReady_d   = 1'b0;
          state_d     = FETCH;
        end
      end
      FETCH: begin
        cnt_d   = CNT_W'(RD_LATENCY - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          rData_d  = err_q ? '0 : reg_rd_data;
          rResp_d  = (err_q || reg_rd_err) ? RESP_SLVERR : RESP_OKAY;
          rValid_d = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (RREADY) begin
          rValid_d  = 1'b0;
          arReady_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ARREADY     = arReady_q;
  assign RVALID      = rValid_q;
  assign RDATA       = rData_q;
  assign RRESP       = rResp_q;
  assign reg_rd_en   = regRdEn_q;
  assign reg_rd_addr = regRdAddr_q;

endmodule

// File: tb/tb_axi4l_read_slave.sv
// ---------------------------------------------------------------------------
// tb_axi4l_read_slave
// Directed bench for axi4l_read_slave. Two instances: dutA with
// RD_LATENCY=1, SECURE_ONLY=1 and dutB with RD_LATENCY=4, SECURE_ONLY=0.
// Each has its own register-file model whose data is only correct on the
// exact cycle RD_LATENCY after the strobe.
// ---------------------------------------------------------------------------
module tb_axi4l_read_slave;
  import axi4l_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic sel;

  int checkCount;
  int passCount;
  int failCount;

  logic [31:0] regs [16];

  logic        aArvalid, aArready, aRvalid, aRready, aRegEn, aRegErr, aInjErr;
  logic [31:0] aAraddr, aRdata, aRegAddr, aRegData;
  logic [2:0]  aArprot;
  logic [1:0]  aRresp;

  logic        bArvalid, bArready, bRvalid, bRready, bRegEn, bRegErr, bInjErr;
  logic [31:0] bAraddr, bRdata, bRegAddr, bRegData;
  logic [2:0]  bArprot;
  logic [1:0]  bRresp;
  logic [31:0] bPipe [4];
  logic [3:0]  bErrPipe;

  logic        oArready, oRvalid, oRegEn;
  logic [31:0] oRdata, oRegAddr;
  logic [1:0]  oRresp;

  always #5 clk = ~clk;

  axi4l_read_slave #(
    .ADDR_W(32), .DATA_W(32), .NUM_REGS(16), .RD_LATENCY(1), .SECURE_ONLY(1)
  ) dutA (
    .ACLK(clk), .ARESETn(reset),
    .ARVALID(aArvalid), .ARREADY(aArready), .ARADDR(aAraddr), .ARPROT(aArprot),
    .RVALID(aRvalid), .RREADY(aRready), .RDATA(aRdata), .RRESP(aRresp),
    .reg_rd_en(aRegEn), .reg_rd_addr(aRegAddr),
    .reg_rd_data(aRegData), .reg_rd_err(aRegErr)
  );

  axi4l_read_slave #(
    .ADDR_W(32), .DATA_W(32), .NUM_REGS(16), .RD_LATENCY(4), .SECURE_ONLY(0)
  ) dutB (
    .ACLK(clk), .ARESETn(reset),
    .ARVALID(bArvalid), .ARREADY(bArready), .ARADDR(bAraddr), .ARPROT(bArprot),
    .RVALID(bRvalid), .RREADY(bRready), .RDATA(bRdata), .RRESP(bRresp),
    .reg_rd_en(bRegEn), .reg_rd_addr(bRegAddr),
    .reg_rd_data(bRegData), .reg_rd_err(bRegErr)
  );

  // Latency-1 register file: data appears one cycle after the strobe and is
  // garbage on every other cycle.
  always @(posedge clk) begin
    aRegData <= aRegEn ? regs[aRegAddr[5:2]] : 32'hBAD0_BAD0;
    aRegErr  <= aRegEn & aInjErr;
  end

  // Latency-4 register file: four-stage delay line behind the strobe.
  always @(posedge clk) begin
    bPipe[0] <= bRegEn ? regs[bRegAddr[5:2]] : 32'hBAD0_BAD0;
    bPipe[1] <= bPipe[0];
    bPipe[2] <= bPipe[1];
    bPipe[3] <= bPipe[2];
    bErrPipe <= {bErrPipe[2:0], bRegEn & bInjErr};
  end
  assign bRegData = bPipe[3];
  assign bRegErr  = bErrPipe[3];

  // Observation mux so the same checking tasks serve both instances.
  assign oArready = sel ? bArready : aArready;
  assign oRvalid  = sel ? bRvalid  : aRvalid;
  assign oRegEn   = sel ? bRegEn   : aRegEn;
  assign oRdata   = sel ? bRdata   : aRdata;
  assign oRegAddr = sel ? bRegAddr : aRegAddr;
  assign oRresp   = sel ? bRresp   : aRresp;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic valid,
                               input logic [31:0] addr, input logic [2:0] prot);
    if (s) begin
      bArvalid = valid; bAraddr = addr; bArprot = prot;
    end else begin
      aArvalid = valid; aAraddr = addr; aArprot = prot;
    end
  endtask

  task automatic checkReset(input logic s, input string tag);
    sel = s;
    #1;
    checkOutput({tag, ".arready"}, 32'(oArready), 32'd0);
    checkOutput({tag, ".rvalid"},  32'(oRvalid),  32'd0);
    checkOutput({tag, ".rdata"},   oRdata,        32'd0);
    checkOutput({tag, ".rresp"},   32'(oRresp),   32'(RESP_OKAY));
    checkOutput({tag, ".regen"},   32'(oRegEn),   32'd0);
    checkOutput({tag, ".regaddr"}, oRegAddr,      32'd0);
  endtask

  // One read from an idle slave, called at a falling edge. Checks the
  // strobe, that RVALID stays low for exactly lat+1 edges after the AR
  // handshake, then the response; optionally completes the R handshake
  // (RREADY must already be high).
  task automatic runRead(input logic s, input string tag, input logic [31:0] addr,
                         input logic [2:0] prot, input int lat,
                         input logic [31:0] expData, input logic [1:0] expResp,
                         input logic expEn, input logic complete);
    sel = s;
    #1;
    checkOutput({tag, ".arready"}, 32'(oArready), 32'd1);
    applyStimulus(s, 1'b1, addr, prot);
    @(negedge clk);
    applyStimulus(s, 1'b0, 32'hFFFF_FFF0, 3'b010);
    checkOutput({tag, ".arready_low"}, 32'(oArready), 32'd0);
    checkOutput({tag, ".regen"}, 32'(oRegEn), 32'(expEn));
    if (expEn) checkOutput({tag, ".regaddr"}, oRegAddr, addr);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      checkOutput({tag, ".rvalid_early"}, 32'(oRvalid), 32'd0);
      checkOutput({tag, ".regen_pulse"}, 32'(oRegEn), 32'd0);
    end
    @(negedge clk);
    checkOutput({tag, ".rvalid"}, 32'(oRvalid), 32'd1);
    checkOutput({tag, ".rdata"}, oRdata, expData);
    checkOutput({tag, ".rresp"}, 32'(oRresp), 32'(expResp));
    if (complete) begin
      @(negedge clk);
      checkOutput({tag, ".rvalid_done"}, 32'(oRvalid), 32'd0);
      checkOutput({tag, ".arready_back"}, 32'(oArready), 32'd1);
    end
  endtask

  // Directed sequence: reset, legal reads, backpressure, error cases,
  // long latency, and reset in the middle of a read.
  initial begin
    checkCount = 0;
    passCount  = 0;
    failCount  = 0;
    for (int i = 0; i < 16; i++) regs[i] = 32'hA5A5_0000 | 32'(i);
    regs[0]  = 32'h0123_4567;
    regs[1]  = 32'h1111_2222;
    regs[2]  = 32'hDEAD_BEEF;
    regs[3]  = 32'h3333_4444;
    regs[15] = 32'hF00D_CAFE;
    sel = 1'b0;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 3'b000);
    applyStimulus(1'b1, 1'b0, 32'h0, 3'b000);
    aRready = 1'b1; bRready = 1'b1;
    aInjErr = 1'b0; bInjErr = 1'b0;

    repeat (2) @(negedge clk);
    checkReset(1'b0, "rstA");
    checkReset(1'b1, "rstB");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    runRead(1'b0, "legal8", 32'h8, 3'b000, 1, 32'hDEAD_BEEF, RESP_OKAY, 1'b1, 1'b1);

    // Backpressure with a second request waiting on AR.
    aRready = 1'b0;
    runRead(1'b0, "bp", 32'h8, 3'b000, 1, 32'hDEAD_BEEF, RESP_OKAY, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h4, 3'b000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp.hold_rvalid",  32'(oRvalid),  32'd1);
      checkOutput("bp.hold_rdata",   oRdata,        32'hDEAD_BEEF);
      checkOutput("bp.hold_rresp",   32'(oRresp),   32'(RESP_OKAY));
      checkOutput("bp.hold_arready", 32'(oArready), 32'd0);
      checkOutput("bp.hold_regen",   32'(oRegEn),   32'd0);
    end
    aRready = 1'b1;
    @(negedge clk);
    checkOutput("bp.rdone_rvalid",  32'(oRvalid),  32'd0);
    checkOutput("bp.rdone_arready", 32'(oArready), 32'd1);
    checkOutput("bp.rdone_regen",   32'(oRegEn),   32'd0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, 3'b000);
    checkOutput("bp2.arready_low", 32'(oArready), 32'd0);
    checkOutput("bp2.regen",       32'(oRegEn),   32'd1);
    checkOutput("bp2.regaddr",     oRegAddr,      32'h4);
    @(negedge clk);
    checkOutput("bp2.rvalid_early", 32'(oRvalid), 32'd0);
    @(negedge clk);
    checkOutput("bp2.rvalid", 32'(oRvalid), 32'd1);
    checkOutput("bp2.rdata",  oRdata,       32'h1111_2222);
    checkOutput("bp2.rresp",  32'(oRresp),  32'(RESP_OKAY));
    @(negedge clk);
    checkOutput("bp2.rvalid_done", 32'(oRvalid), 32'd0);

    // Error cases and the top legal address on the latency-1 slave.
    runRead(1'b0, "oob40", 32'h40, 3'b000, 1, 32'h0, RESP_SLVERR, 1'b0, 1'b1);
    runRead(1'b0, "top3C", 32'h3C, 3'b000, 1, 32'hF00D_CAFE, RESP_OKAY, 1'b1, 1'b1);
    runRead(1'b0, "unal6", 32'h6, 3'b000, 1, 32'h0, RESP_SLVERR, 1'b0, 1'b1);
    runRead(1'b0, "nonsec", 32'h4, 3'b010, 1, 32'h0, RESP_SLVERR, 1'b0, 1'b1);
    runRead(1'b0, "prot101", 32'h4, 3'b101, 1, 32'h1111_2222, RESP_OKAY, 1'b1, 1'b1);
    aInjErr = 1'b1;
    runRead(1'b0, "rderr", 32'h0, 3'b000, 1, 32'h0123_4567, RESP_SLVERR, 1'b1, 1'b1);
    aInjErr = 1'b0;

    // Latency-4 slave; non-secure access is legal when not blocked.
    runRead(1'b1, "l4legal", 32'hC, 3'b010, 4, 32'h3333_4444, RESP_OKAY, 1'b1, 1'b1);
    runRead(1'b1, "l4oob", 32'h40, 3'b000, 4, 32'h0, RESP_SLVERR, 1'b0, 1'b1);

    // Reset while the latency-4 slave is counting down in WAIT.
    sel = 1'b1;
    applyStimulus(1'b1, 1'b1, 32'h8, 3'b000);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'h0, 3'b000);
    repeat (2) @(negedge clk);
    checkOutput("rstWait.pre_rvalid", 32'(oRvalid), 32'd0);
    reset = 1'b1;
    checkReset(1'b1, "rstWait");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    runRead(1'b1, "postRstB", 32'h0, 3'b000, 4, 32'h0123_4567, RESP_OKAY, 1'b1, 1'b1);

    // Reset while the latency-1 slave holds a response in RESP.
    aRready = 1'b0;
    runRead(1'b0, "stall", 32'h8, 3'b000, 1, 32'hDEAD_BEEF, RESP_OKAY, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    checkReset(1'b0, "rstResp");
    @(negedge clk);
    reset = 1'b0;
    aRready = 1'b1;
    @(negedge clk);
    runRead(1'b0, "postRstA", 32'h0, 3'b000, 1, 32'h0123_4567, RESP_OKAY, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
